// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences Fetch/Decode/execute states and drives
// every datapath select and write enable, flagging unsupported encodings.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_function,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       pc_write,
    output logic       old_pc_write,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP_PC, S_JALR_PC, S_LINK, S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLTU = 3'd6;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    state_t state_q, state_d;
    logic   mem_write_raw, ir_write_raw, reg_write_raw, pc_write_raw;
    logic   old_pc_write_raw, illegal_raw;
    logic [2:0] op_fn;
    logic       op_ok;
    logic       unused_f7;

    // Only the bit that distinguishes sub from add matters here.
    assign unused_f7 = ^{f7[6], f7[4:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Shared R/I-type function decode; sub exists only for register-register ops.
    always_comb begin
        op_fn = ALU_ADD;
        op_ok = 1'b1;
        case (f3)
            3'b000:  op_fn = (state_q == S_EXEC_R && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  op_fn = ALU_AND;
            3'b110:  op_fn = ALU_OR;
            3'b100:  op_fn = ALU_XOR;
            3'b010:  op_fn = ALU_SLT;
            3'b011:  op_fn = ALU_SLTU;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        adr_src          = 1'b0;
        mem_write_raw    = 1'b0;
        ir_write_raw     = 1'b0;
        imm_src          = IMM_I;
        alu_src_a        = 2'd0;
        alu_src_b        = 2'd0;
        alu_function     = ALU_ADD;
        result_src       = 2'd0;
        reg_write_raw    = 1'b0;
        pc_write_raw     = 1'b0;
        old_pc_write_raw = 1'b0;
        illegal_raw      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_raw     = 1'b1;
                old_pc_write_raw = 1'b1;
                alu_src_b        = 2'd2;
                result_src       = 2'd2;
                pc_write_raw     = 1'b1;
                state_d          = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes oldPC + B-immediate so BRANCH can use it later.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JUMP_PC;
                    OP_JALR:           state_d = S_JALR_PC;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src    = 2'd1;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a    = 2'd2;
                alu_src_b    = (state_q == S_EXEC_I) ? 2'd1 : 2'd0;
                alu_function = op_fn;
                illegal_raw  = !op_ok;
                state_d      = op_ok ? S_ALU_WB : S_FETCH;
            end
            S_ALU_WB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                state_d   = S_FETCH;
                case (f3)
                    3'b000: begin alu_function = ALU_SUB; pc_write_raw = zero;  end
                    3'b001: begin alu_function = ALU_SUB; pc_write_raw = !zero; end
                    3'b100: begin alu_function = ALU_SLT; pc_write_raw = !zero; end
                    3'b101: begin alu_function = ALU_SLT; pc_write_raw = zero;  end
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_JUMP_PC, S_JALR_PC: begin
                // PC is redirected before the link write so rd==rs1 still sees old rs1.
                alu_src_a    = (state_q == S_JALR_PC) ? 2'd2 : 2'd1;
                alu_src_b    = 2'd1;
                imm_src      = (state_q == S_JALR_PC) ? IMM_I : IMM_J;
                result_src   = 2'd2;
                pc_write_raw = 1'b1;
                state_d      = S_LINK;
            end
            S_LINK: begin
                alu_src_a     = 2'd1;
                alu_src_b     = 2'd2;
                result_src    = 2'd2;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_LUI: begin
                imm_src       = IMM_U;
                result_src    = 2'd3;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH; keep its enables quiet until reset drops.
    assign mem_write    = mem_write_raw    & ~reset;
    assign ir_write     = ir_write_raw     & ~reset;
    assign reg_write    = reg_write_raw    & ~reset;
    assign pc_write     = pc_write_raw     & ~reset;
    assign old_pc_write = old_pc_write_raw & ~reset;
    assign illegal      = illegal_raw      & ~reset;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed vector table, reset corner case and
// randomized instructions checked cycle-by-cycle against an instruction-level model.
module tb_multi_cycle_controller;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    logic       clk, reset, zero;
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write, illegal;
    logic [2:0] imm_src, alu_function;
    logic [1:0] alu_src_a, alu_src_b, result_src;

    multi_cycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_function(alu_function),
        .result_src(result_src), .reg_write(reg_write), .pc_write(pc_write),
        .old_pc_write(old_pc_write), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle; c_* flags mark which selects are defined.
    typedef struct packed {
        logic adr; logic [2:0] imm; logic [1:0] a; logic [1:0] b; logic [2:0] fn; logic [1:0] rs;
        logic mw; logic ir; logic rw; logic pc; logic opc; logic ill;
        logic c_adr; logic c_imm; logic c_a; logic c_b; logic c_fn; logic c_rs;
    } exp_t;

    typedef struct {
        string name; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z;
        int ci; bit fc; logic [2:0] fn; logic pc; logic rw; logic ill;
    } vec_t;

    exp_t exp_q[$];
    vec_t vq[$];
    logic [2:0] obs_fn [0:15];
    logic       obs_pc [0:15];
    logic       obs_rw [0:15];
    logic       obs_ill[0:15];
    int passed = 0, total = 0;

    function automatic exp_t mk(int adr, int imm, int a, int b, int fn, int rs,
                                bit mw, bit ir, bit rw, bit pc, bit opc, bit ill);
        exp_t e = '0;
        if (adr >= 0) begin e.adr = adr[0];   e.c_adr = 1'b1; end
        if (imm >= 0) begin e.imm = imm[2:0]; e.c_imm = 1'b1; end
        if (a >= 0)   begin e.a = a[1:0];     e.c_a = 1'b1;   end
        if (b >= 0)   begin e.b = b[1:0];     e.c_b = 1'b1;   end
        if (fn >= 0)  begin e.fn = fn[2:0];   e.c_fn = 1'b1;  end
        if (rs >= 0)  begin e.rs = rs[1:0];   e.c_rs = 1'b1;  end
        e.mw = mw; e.ir = ir; e.rw = rw; e.pc = pc; e.opc = opc; e.ill = ill;
        return e;
    endfunction

    // ALU operation for R/I arithmetic; returns -1 for unsupported f3.
    function automatic int alu_op(logic [2:0] f, logic [6:0] f7v, bit is_r);
        case (f)
            3'b000:  return (is_r && f7v[5]) ? 1 : 0;
            3'b111:  return 2;
            3'b110:  return 3;
            3'b100:  return 4;
            3'b010:  return 5;
            3'b011:  return 6;
            default: return -1;
        endcase
    endfunction

    // Instruction-level model: the full per-cycle output sequence of one instruction.
    task automatic build(input logic [6:0] op, input logic [2:0] fv, input logic [6:0] f7v,
                         input logic zv);
        bit legal;
        int fn;
        exp_q.delete();
        legal = op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        exp_q.push_back(mk(0, -1, 0, 2, 0, 2, 0, 1, 0, 1, 1, 0));
        exp_q.push_back(mk(-1, 2, 1, 1, 0, -1, 0, 0, 0, 0, 0, !legal));
        if (op == OP_LOAD || op == OP_STORE) begin
            exp_q.push_back(mk(-1, op == OP_STORE ? 1 : 0, 2, 1, 0, -1, 0, 0, 0, 0, 0, 0));
            if (op == OP_STORE)
                exp_q.push_back(mk(1, -1, -1, -1, -1, 0, 1, 0, 0, 0, 0, 0));
            else begin
                exp_q.push_back(mk(1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(-1, -1, -1, -1, -1, 1, 0, 0, 1, 0, 0, 0));
            end
        end else if (op == OP_R || op == OP_I) begin
            fn = alu_op(fv, f7v, op == OP_R);
            exp_q.push_back(mk(-1, op == OP_I ? 0 : -1, 2, op == OP_I ? 1 : 0, fn, -1,
                               0, 0, 0, 0, 0, fn < 0));
            if (fn >= 0) exp_q.push_back(mk(-1, -1, -1, -1, -1, 0, 0, 0, 1, 0, 0, 0));
        end else if (op == OP_BR) begin
            case (fv)
                3'b000:  exp_q.push_back(mk(-1, -1, 2, 0, 1, 0, 0, 0, 0, zv, 0, 0));
                3'b001:  exp_q.push_back(mk(-1, -1, 2, 0, 1, 0, 0, 0, 0, !zv, 0, 0));
                3'b100:  exp_q.push_back(mk(-1, -1, 2, 0, 5, 0, 0, 0, 0, !zv, 0, 0));
                3'b101:  exp_q.push_back(mk(-1, -1, 2, 0, 5, 0, 0, 0, 0, zv, 0, 0));
                default: exp_q.push_back(mk(-1, -1, 2, 0, -1, 0, 0, 0, 0, 0, 0, 1));
            endcase
        end else if (op == OP_JAL || op == OP_JALR) begin
            if (op == OP_JAL) exp_q.push_back(mk(-1, 3, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0));
            else              exp_q.push_back(mk(-1, 0, 2, 1, 0, 2, 0, 0, 0, 1, 0, 0));
            exp_q.push_back(mk(-1, -1, 1, 2, 0, 2, 0, 0, 1, 0, 0, 0));
        end else if (op == OP_LUI) begin
            exp_q.push_back(mk(-1, 4, -1, -1, -1, 3, 0, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic check_cycle(input string tag, input int step, input exp_t e);
        logic [5:0]  got_we, want_we;
        logic [14:0] got_sel, want_sel;
        bit ok;
        got_we  = {mem_write, ir_write, reg_write, pc_write, old_pc_write, illegal};
        want_we = {e.mw, e.ir, e.rw, e.pc, e.opc, e.ill};
        got_sel  = {adr_src, imm_src, alu_src_a, alu_src_b, alu_function, result_src};
        want_sel = {e.adr, e.imm, e.a, e.b, e.fn, e.rs};
        ok = (got_we == want_we)
          && (!e.c_adr || adr_src == e.adr) && (!e.c_imm || imm_src == e.imm)
          && (!e.c_a || alu_src_a == e.a) && (!e.c_b || alu_src_b == e.b)
          && (!e.c_fn || alu_function == e.fn) && (!e.c_rs || result_src == e.rs);
        total++;
        if (ok) passed++;
        else $display("FAIL %s step %0d: got we=%b sel=%h, required we=%b sel=%h (care %b)",
                      tag, step, got_we, got_sel, want_we, want_sel,
                      {e.c_adr, e.c_imm, e.c_a, e.c_b, e.c_fn, e.c_rs});
    endtask

    task automatic check_we_zero(input string tag);
        logic [5:0] got_we;
        got_we = {mem_write, ir_write, reg_write, pc_write, old_pc_write, illegal};
        total++;
        if (got_we == 6'b0) passed++;
        else $display("FAIL %s: got we=%b, required 000000", tag, got_we);
    endtask

    // Starts just after a rising edge with the FSM in FETCH; limit>0 stops early.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] fv,
                             input logic [6:0] f7v, input logic zv, input int limit);
        int n;
        opcode = op; f3 = fv; f7 = f7v; zero = zv;
        build(op, fv, f7v, zv);
        n = exp_q.size();
        if (limit > 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cycle(tag, i, exp_q[i]);
            obs_fn[i] = alu_function; obs_pc[i] = pc_write;
            obs_rw[i] = reg_write;    obs_ill[i] = illegal;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t v(string name, logic [6:0] op, logic [2:0] fv, logic [6:0] f7v,
                               logic z, int ci, bit fc, logic [2:0] fn, logic pc, logic rw,
                               logic ill);
        vec_t r;
        r.name = name; r.op = op; r.f3 = fv; r.f7 = f7v; r.z = z; r.ci = ci;
        r.fc = fc; r.fn = fn; r.pc = pc; r.rw = rw; r.ill = ill;
        return r;
    endfunction

    initial begin
        logic [6:0] rop;
        logic [3:0] got4, want4;
        reset = 1'b1; opcode = '0; f3 = '0; f7 = '0; zero = 1'b0;

        // Table: inputs, then the cycle index observed and its expected fn/pc_write/reg_write/illegal.
        vq.push_back(v("lw",      OP_LOAD,  3'b010, 7'h00, 0, 2, 1, 3'd0, 0, 0, 0));
        vq.push_back(v("sw",      OP_STORE, 3'b010, 7'h00, 0, 2, 1, 3'd0, 0, 0, 0));
        vq.push_back(v("add",     OP_R,     3'b000, 7'h00, 0, 2, 1, 3'd0, 0, 0, 0));
        vq.push_back(v("sub",     OP_R,     3'b000, 7'h20, 0, 2, 1, 3'd1, 0, 0, 0));
        vq.push_back(v("sub_wb",  OP_R,     3'b000, 7'h20, 0, 3, 0, 3'd0, 0, 1, 0));
        vq.push_back(v("addi_f7", OP_I,     3'b000, 7'h20, 0, 2, 1, 3'd0, 0, 0, 0));
        vq.push_back(v("and",     OP_R,     3'b111, 7'h00, 0, 2, 1, 3'd2, 0, 0, 0));
        vq.push_back(v("xori",    OP_I,     3'b100, 7'h00, 0, 2, 1, 3'd4, 0, 0, 0));
        vq.push_back(v("sltu",    OP_R,     3'b011, 7'h00, 0, 2, 1, 3'd6, 0, 0, 0));
        vq.push_back(v("beq_z1",  OP_BR,    3'b000, 7'h00, 1, 2, 1, 3'd1, 1, 0, 0));
        vq.push_back(v("beq_z0",  OP_BR,    3'b000, 7'h00, 0, 2, 1, 3'd1, 0, 0, 0));
        vq.push_back(v("bne_z1",  OP_BR,    3'b001, 7'h00, 1, 2, 1, 3'd1, 0, 0, 0));
        vq.push_back(v("bge_z0",  OP_BR,    3'b101, 7'h00, 0, 2, 1, 3'd5, 0, 0, 0));
        vq.push_back(v("blt_z0",  OP_BR,    3'b100, 7'h00, 0, 2, 1, 3'd5, 1, 0, 0));
        vq.push_back(v("jalr",    OP_JALR,  3'b000, 7'h00, 0, 2, 1, 3'd0, 1, 0, 0));
        vq.push_back(v("jalr_lk", OP_JALR,  3'b000, 7'h00, 0, 3, 1, 3'd0, 0, 1, 0));
        vq.push_back(v("jal",     OP_JAL,   3'b000, 7'h00, 0, 2, 1, 3'd0, 1, 0, 0));
        vq.push_back(v("lui",     OP_LUI,   3'b000, 7'h00, 0, 2, 0, 3'd0, 0, 1, 0));
        vq.push_back(v("bad_op",  7'h7f,    3'b000, 7'h00, 0, 1, 1, 3'd0, 0, 0, 1));
        vq.push_back(v("r_f3_1",  OP_R,     3'b001, 7'h00, 0, 2, 0, 3'd0, 0, 0, 1));
        vq.push_back(v("br_f3_2", OP_BR,    3'b010, 7'h00, 1, 2, 0, 3'd0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_we_zero("reset_hold");
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vq[k]) begin
            run_instr(vq[k].name, vq[k].op, vq[k].f3, vq[k].f7, vq[k].z, 0);
            got4  = {vq[k].fc ? obs_fn[vq[k].ci] : 3'd0, obs_pc[vq[k].ci]};
            want4 = {vq[k].fc ? vq[k].fn : 3'd0, vq[k].pc};
            total++;
            if (got4 == want4 && obs_rw[vq[k].ci] == vq[k].rw && obs_ill[vq[k].ci] == vq[k].ill)
                passed++;
            else
                $display("FAIL vec_%s: got fn/pc=%h rw=%b ill=%b, required fn/pc=%h rw=%b ill=%b",
                         vq[k].name, got4, obs_rw[vq[k].ci], obs_ill[vq[k].ci],
                         want4, vq[k].rw, vq[k].ill);
        end

        // Reset in the middle of MEM_READ abandons the load.
        run_instr("lw_pre_rst", OP_LOAD, 3'b010, 7'h00, 0, 3);
        #2 reset = 1'b1;
        #1 check_we_zero("reset_async");
        @(negedge clk);
        check_we_zero("reset_mid");
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr("after_rst", OP_R, 3'b110, 7'h00, 0, 0);

        for (int r = 0; r < 80; r++) begin
            case ($urandom_range(0, 9))
                0: rop = OP_LOAD;  1: rop = OP_STORE; 2: rop = OP_R;   3: rop = OP_I;
                4: rop = OP_BR;    5: rop = OP_JAL;   6: rop = OP_JALR; 7: rop = OP_LUI;
                default: rop = 7'($urandom);
            endcase
            run_instr($sformatf("rand%0d", r), rop, 3'($urandom),
                      $urandom_range(0, 1) ? 7'h20 : 7'($urandom), 1'($urandom), 0);
        end
        run_instr("final", OP_LUI, 3'b000, 7'h00, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
